// File: rtl/clock_time_gen.sv
// rtl/clock_time_gen.sv - BCD 24 h time-of-day source with set keys and field blink
// Drives six display digits; 4'hA is the display's blank code used for blinking.
module clock_time_gen #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] m0,
    output logic [3:0] m1,
    output logic [3:0] h0,
    output logic [3:0] h1,
    output logic [1:0] mode,
    output logic       tick_1hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             hidden_q, hidden_d;
    logic             tick_q, tick_d;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       hrs_q, hrs_d;
    logic             tick_fire;
    logic             inc_accept;

    // Packed two-digit BCD increments; wrap values keep digits in range.
    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A mode key always wins: it swallows a coincident tick or increment.
    assign tick_fire  = (state_q == RUN) && (cnt_q == CNT_MAX) && !key_mode;
    assign inc_accept = (state_q != RUN) && key_inc && !key_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (key_mode) begin
            unique case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                SET_SEC:  state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        if (state_q != RUN || key_mode || cnt_q == CNT_MAX)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(1);
        tick_d = tick_fire;
    end

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hrs_d = hrs_q;
        if (tick_fire) begin
            sec_d = inc_bcd60(sec_q);
            if (sec_q == 8'h59) begin
                min_d = inc_bcd60(min_q);
                if (min_q == 8'h59)
                    hrs_d = inc_bcd24(hrs_q);
            end
        end else if (inc_accept) begin
            unique case (state_q)
                SET_HOUR: hrs_d = inc_bcd24(hrs_q);
                SET_MIN:  min_d = inc_bcd60(min_q);
                SET_SEC:  sec_d = inc_bcd60(sec_q);
                default:  ;
            endcase
        end
    end

    // Blink restarts visible on any mode change or edit so the new value is seen.
    always_comb begin
        blk_d    = blk_q;
        hidden_d = hidden_q;
        if (state_q == RUN || state_d != state_q || inc_accept) begin
            blk_d    = '0;
            hidden_d = 1'b0;
        end else if (blk_q == BLK_MAX) begin
            blk_d    = '0;
            hidden_d = ~hidden_q;
        end else begin
            blk_d = blk_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            blk_q    <= '0;
            hidden_q <= 1'b0;
            tick_q   <= 1'b0;
            sec_q    <= 8'h00;
            min_q    <= 8'h00;
            hrs_q    <= 8'h00;
        end else begin
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            hidden_q <= hidden_d;
            tick_q   <= tick_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hrs_q    <= hrs_d;
        end
    end

    always_comb begin
        mode     = state_q;
        tick_1hz = tick_q;
        h1       = hrs_q[7:4];
        h0       = hrs_q[3:0];
        m1       = min_q[7:4];
        m0       = min_q[3:0];
        s1       = sec_q[7:4];
        s0       = sec_q[3:0];
        if (hidden_q) begin
            unique case (state_q)
                SET_HOUR: begin h1 = 4'hA; h0 = 4'hA; end
                SET_MIN:  begin m1 = 4'hA; m0 = 4'hA; end
                SET_SEC:  begin s1 = 4'hA; s0 = 4'hA; end
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_gen.sv
// tb/tb_clock_time_gen.sv - directed self-checking bench for clock_time_gen
module tb_clock_time_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic [1:0] mode;
    logic       tick_1hz;
    logic [23:0] disp;

    int n_checks = 0;
    int n_fail   = 0;

    clock_time_gen #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .s0       (s0),
        .s1       (s1),
        .m0       (m0),
        .m1       (m1),
        .h0       (h0),
        .h1       (h1),
        .mode     (mode),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    assign disp = {h1, h0, m1, m0, s1, s0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_mode();
        key_mode = 1'b1;
        step(1);
        key_mode = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            key_inc = 1'b1;
            step(1);
            key_inc = 1'b0;
        end
    endtask

    initial begin
        // reset state
        step(2);
        check("rst_disp", 32'(disp), 32'h000000);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_tick", 32'(tick_1hz), 32'd0);
        rst_n = 1'b1;

        // free run: tick every 4th cycle, s0 counts up
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("run_tick_%0d", k), 32'(tick_1hz), (k % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("run_disp_%0d", k), 32'(disp), 32'(k / 4));
        end

        // set 09:59:59 then tick to 10:00:00
        pulse_mode();
        check("sethour_mode", 32'(mode), 32'd1);
        check("sethour_tick", 32'(tick_1hz), 32'd0);
        pulse_inc(9);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        pulse_inc(56);
        check("set_095959", 32'(disp), 32'h095959);
        pulse_mode();
        check("back_run_mode", 32'(mode), 32'd0);
        step(3);
        check("pre_tick_disp", 32'(disp), 32'h095959);
        check("pre_tick_flag", 32'(tick_1hz), 32'd0);
        step(1);
        check("roll_100000", 32'(disp), 32'h100000);
        check("roll_tick", 32'(tick_1hz), 32'd1);

        // set 23:59:59 then midnight rollover with a single pulse
        pulse_mode();
        pulse_inc(13);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        pulse_inc(59);
        check("set_235959", 32'(disp), 32'h235959);
        pulse_mode();
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("mid_tick_%0d", k), 32'(tick_1hz), (k == 4) ? 32'd1 : 32'd0);
        end
        check("mid_000000", 32'(disp), 32'h000000);
        step(1);
        check("mid_single", 32'(tick_1hz), 32'd0);

        // hours wrap 23 -> 00 in SET_HOUR, no carry, no ticks
        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(7);
        pulse_mode();
        pulse_inc(5);
        check("set_230705", 32'(disp), 32'h230705);
        pulse_mode();
        pulse_mode();
        check("rehour_mode", 32'(mode), 32'd1);
        check("rehour_disp", 32'(disp), 32'h230705);
        pulse_inc(1);
        check("hour_wrap", 32'(disp), 32'h000705);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("frozen_tick_%0d", k), 32'(tick_1hz), 32'd0);
        end
        check("frozen_ms", 32'(disp[15:0]), 32'h0705);

        // blink in SET_MIN
        pulse_mode();
        check("setmin_mode", 32'(mode), 32'd2);
        step(2);
        check("blink_vis0", 32'(disp), 32'h000705);
        step(1);
        check("blink_hid0", 32'(disp), 32'h00AA05);
        step(3);
        check("blink_vis1", 32'(disp), 32'h000705);
        step(4);
        check("blink_hid1", 32'(disp), 32'h00AA05);
        pulse_inc(1);
        check("blink_inc", 32'(disp), 32'h000805);

        // simultaneous keys in SET_HOUR
        pulse_mode();
        pulse_mode();
        pulse_mode();
        check("sim_pre_mode", 32'(mode), 32'd1);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        step(1);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        check("sim_mode", 32'(mode), 32'd2);
        check("sim_disp", 32'(disp), 32'h000805);

        // asynchronous reset mid-blink in SET_SEC
        pulse_mode();
        check("setsec_mode", 32'(mode), 32'd3);
        step(2);
        rst_n = 1'b0;
        #1;
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_disp", 32'(disp), 32'h000000);
        check("arst_tick", 32'(tick_1hz), 32'd0);
        step(1);
        rst_n = 1'b1;

        // mode key coincident with a tick discards the tick
        step(3);
        check("coinc_pre", 32'(disp), 32'h000000);
        key_mode = 1'b1;
        step(1);
        key_mode = 1'b0;
        check("coinc_mode", 32'(mode), 32'd1);
        check("coinc_disp", 32'(disp), 32'h000000);
        check("coinc_tick", 32'(tick_1hz), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
